// File: rtl/dmem_pkg.sv
// Shared types and helpers for the big-endian data-memory responder.
package dmem_pkg;

  localparam int unsigned DMEM_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dmem_state_e;

  // Lowest byte address ends up in the most significant byte.
  function automatic logic [31:0] dmem_pack_word(input logic [7:0] b0, input logic [7:0] b1,
                                                 input logic [7:0] b2, input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// Loadable down-counter; done flags the cycle whose edge takes the count 1 -> 0.
module dmem_wait_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [Width-1:0] count_q, count_d;

  // Load has priority; decrement only while enabled and not already empty.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  assign done = en && (count_q == Width'(1));

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Word-access, big-endian data memory behind valid/ready request and response channels,
// with WAIT_CYC wait states and misalignment flagging.
// Optional: define DMEM_BYTE_STROBE_EN to add req_be byte enables for stores.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned Aw = $clog2(DEPTH);

  dmem_state_e    state_q, state_d;
  logic [Aw-1:0]  addr_q;
  logic           write_q;
  logic [31:0]    wdata_q;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [7:0]     mem_q [DEPTH];

  logic           accept;
  logic           cnt_done;
  logic           enter_resp;
  logic [Aw-1:0]  acc_addr;
  logic [Aw-1:0]  word_base;
  logic           acc_write;
  logic [31:0]    acc_wdata;
  logic [3:0]     acc_be;
  logic           misaligned;
  logic           mem_we;
  logic           unused_addr;

  assign unused_addr = ^req_addr[31:Aw];
  assign accept      = (state_q == StIdle) && req_valid;

  dmem_wait_counter #(
    .Width (4)
  ) u_wait_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept && (WAIT_CYC != 0)),
    .load_val (4'(WAIT_CYC)),
    .en       (state_q == StWait),
    .done     (cnt_done)
  );

  // With WAIT_CYC = 0 the access happens on the acceptance edge, so use the live request.
  always_comb begin
    acc_addr  = (state_q == StIdle) ? req_addr[Aw-1:0] : addr_q;
    acc_write = (state_q == StIdle) ? req_write : write_q;
    acc_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
  end

`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0] be_q;

  assign acc_be = (state_q == StIdle) ? req_be : be_q;

  // Byte-enable latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      be_q <= '0;
    end else if (accept) begin
      be_q <= req_be;
    end
  end
`else
  assign acc_be = 4'hF;
`endif

  assign misaligned = |acc_addr[1:0];
  assign word_base  = acc_addr & ~Aw'(3);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = (WAIT_CYC == 0) ? StResp : StWait;
      StWait: if (cnt_done) state_d = StResp;
      StResp: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign enter_resp = (state_d == StResp) && (state_q != StResp);
  assign mem_we     = enter_resp && acc_write && !misaligned;

  // Response data captured on RESP entry, held until handshake, then cleared.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d   = misaligned;
      rdata_d = '0;
      if (!acc_write && !misaligned) begin
        rdata_d = dmem_pack_word(mem_q[word_base], mem_q[word_base | Aw'(1)],
                                 mem_q[word_base | Aw'(2)], mem_q[word_base | Aw'(3)]);
      end
    end else if ((state_q == StResp) && rsp_ready) begin
      rdata_d = '0;
      err_d   = 1'b0;
    end
  end

  // Control and request-latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q  <= req_addr[Aw-1:0];
        write_q <= req_write;
        wdata_q <= req_wdata;
      end
    end
  end

  // Byte storage; enabled bytes of an aligned store land big-endian.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (mem_we) begin
      for (int k = 0; k < DMEM_WORD_BYTES; k++) begin
        if (acc_be[3-k]) mem_q[word_base | Aw'(k)] <= acc_wdata[31-8*k -: 8];
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (WAIT_CYC = 2 and 0) against a byte-array model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WC    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        m_req_valid, m_rsp_ready, z_req_valid, z_rsp_ready;
  logic        m_req_ready, m_rsp_valid, m_rsp_err;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] m_rsp_rdata, z_rsp_rdata;

  logic        sel;
  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;

  logic [7:0]  mdl [2][DEPTH];
  int          n_pass, n_total;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYC(WC)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (m_req_valid),
    .req_ready (m_req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be    (req_be),
`endif
    .rsp_valid (m_rsp_valid),
    .rsp_ready (m_rsp_ready),
    .rsp_rdata (m_rsp_rdata),
    .rsp_err   (m_rsp_err)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYC(0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (z_req_valid),
    .req_ready (z_req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be    (req_be),
`endif
    .rsp_valid (z_rsp_valid),
    .rsp_ready (z_rsp_ready),
    .rsp_rdata (z_rsp_rdata),
    .rsp_err   (z_rsp_err)
  );

  assign o_req_ready = sel ? z_req_ready : m_req_ready;
  assign o_rsp_valid = sel ? z_rsp_valid : m_rsp_valid;
  assign o_rsp_rdata = sel ? z_rsp_rdata : m_rsp_rdata;
  assign o_rsp_err   = sel ? z_rsp_err   : m_rsp_err;

  task automatic set_valid(input logic v);
    if (sel) z_req_valid = v;
    else     m_req_valid = v;
  endtask

  task automatic set_ready(input logic v);
    if (sel) z_rsp_ready = v;
    else     m_rsp_ready = v;
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) mdl[s][i] = 8'h00;
  endtask

  // Reference behaviour: byte memory, big-endian words, addresses taken modulo DEPTH.
  task automatic model(input logic s, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] exp_rdata, output logic exp_err);
    int unsigned a;
    logic [3:0]  be_eff;
    a = addr % DEPTH;
`ifdef DMEM_BYTE_STROBE_EN
    be_eff = be;
`else
    be_eff = 4'hF;
`endif
    exp_err   = (a % 4) != 0;
    exp_rdata = 32'h0;
    if (!exp_err) begin
      if (wr) begin
        for (int k = 0; k < 4; k++)
          if (be_eff[3-k]) mdl[s][a+k] = wd[31-8*k -: 8];
      end else begin
        exp_rdata = {mdl[s][a], mdl[s][a+1], mdl[s][a+2], mdl[s][a+3]};
      end
    end
  endtask

  // Drives one request to completion; reports captured response and timing observations.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input int stall, input logic hold_valid,
                     output logic [31:0] rdata, output logic err, output int lat,
                     output logic stable, output logic ready_after);
    int guard;
    set_valid(1'b1);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    guard     = 0;
    while (!o_req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    if (!hold_valid) set_valid(1'b0);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_write = 1'($urandom);
    req_be    = 4'($urandom);
    lat = 1;
    while (!o_rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata  = o_rsp_rdata;
    err    = o_rsp_err;
    stable = 1'b1;
    repeat (stall) begin
      @(posedge clk); #1;
      if (!o_rsp_valid || o_rsp_rdata !== rdata || o_rsp_err !== err || o_req_ready)
        stable = 1'b0;
    end
    set_ready(1'b1);
    @(posedge clk); #1;
    set_ready(1'b0);
    set_valid(1'b0);
    ready_after = o_req_ready;
  endtask

  // Model plus DUT in one call; comparisons stay in the test tasks.
  task automatic do_op(input logic s, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input int stall,
                       input logic hold_valid, output logic [31:0] rdata, output logic err,
                       output int lat, output logic stable, output logic ready_after,
                       output logic [31:0] exp_rdata, output logic exp_err);
    sel = s;
    model(s, wr, addr, wd, be, exp_rdata, exp_err);
    txn(wr, addr, wd, be, stall, hold_valid, rdata, err, lat, stable, ready_after);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_total++; if (m_req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", m_req_ready); else n_pass++;
    n_total++; if (m_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", m_rsp_valid); else n_pass++;
    n_total++; if (m_rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata: got %h want 0", m_rsp_rdata); else n_pass++;
    n_total++; if (m_rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b want 0", m_rsp_err); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_model();
  endtask

  task automatic test_store_load();
    logic [31:0] rd, er; logic e, ee, st, ra; int lat;
    do_op(1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, e, lat, st, ra, er, ee);
    n_total++; if (lat != WC + 1) $display("FAIL store_latency: got %0d want %0d", lat, WC + 1); else n_pass++;
    n_total++; if (e !== 1'b0) $display("FAIL store_err: got %b want 0", e); else n_pass++;
    n_total++; if (rd !== 32'h0) $display("FAIL store_rdata: got %h want 0", rd); else n_pass++;
    n_total++; if (ra !== 1'b1) $display("FAIL store_ready_after: got %b want 1", ra); else n_pass++;
    do_op(1'b0, 1'b0, 32'h08, 32'h0, 4'hF, 0, 1'b0, rd, e, lat, st, ra, er, ee);
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL load_rdata: got %h want deadbeef", rd); else n_pass++;
    do_op(1'b0, 1'b0, 32'h0C, 32'h0, 4'hF, 0, 1'b0, rd, e, lat, st, ra, er, ee);
    n_total++; if (rd !== er) $display("FAIL load_next_word: got %h want %h", rd, er); else n_pass++;
  endtask

  task automatic test_misaligned();
    logic [31:0] rd, er; logic e, ee, st, ra; int lat;
    do_op(1'b0, 1'b0, 32'h05, 32'h0, 4'hF, 0, 1'b0, rd, e, lat, st, ra, er, ee);
    n_total++; if (e !== 1'b1 || rd !== 32'h0) $display("FAIL misaligned_load: got err=%b rdata=%h want err=1 rdata=0", e, rd); else n_pass++;
    n_total++; if (lat != WC + 1) $display("FAIL misaligned_latency: got %0d want %0d", lat, WC + 1); else n_pass++;
    do_op(1'b0, 1'b1, 32'h0A, 32'h12345678, 4'hF, 0, 1'b0, rd, e, lat, st, ra, er, ee);
    n_total++; if (e !== 1'b1 || rd !== 32'h0) $display("FAIL misaligned_store: got err=%b rdata=%h want err=1 rdata=0", e, rd); else n_pass++;
    do_op(1'b0, 1'b0, 32'h08, 32'h0, 4'hF, 0, 1'b0, rd, e, lat, st, ra, er, ee);
    n_total++; if (rd !== 32'hDEADBEEF || e !== 1'b0) $display("FAIL misaligned_no_update: got %h err=%b want deadbeef err=0", rd, e); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, er; logic e, ee, st, ra; int lat;
    do_op(1'b0, 1'b0, 32'h08, 32'h0, 4'hF, 5, 1'b1, rd, e, lat, st, ra, er, ee);
    n_total++; if (st !== 1'b1) $display("FAIL backpressure_stable: got %b want 1", st); else n_pass++;
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL backpressure_rdata: got %h want deadbeef", rd); else n_pass++;
    n_total++; if (ra !== 1'b1) $display("FAIL backpressure_no_accept: got req_ready=%b want 1", ra); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] rd, er; logic e, ee, st, ra; int lat;
    do_op(1'b1, 1'b1, 32'h7C, 32'hA5A5A5A5, 4'hF, 0, 1'b0, rd, e, lat, st, ra, er, ee);
    n_total++; if (lat != 1) $display("FAIL wait0_latency: got %0d want 1", lat); else n_pass++;
    n_total++; if (ra !== 1'b1) $display("FAIL wait0_ready_after: got %b want 1", ra); else n_pass++;
    do_op(1'b1, 1'b0, 32'h3C, 32'h0, 4'hF, 0, 1'b0, rd, e, lat, st, ra, er, ee);
    n_total++; if (rd !== 32'hA5A5A5A5) $display("FAIL wait0_wrap_readback: got %h want a5a5a5a5", rd); else n_pass++;
    do_op(1'b0, 1'b1, 32'hFFFF_FF7C, 32'h5A5A0FF0, 4'hF, 0, 1'b0, rd, e, lat, st, ra, er, ee);
    do_op(1'b0, 1'b0, 32'h3C, 32'h0, 4'hF, 0, 1'b0, rd, e, lat, st, ra, er, ee);
    n_total++; if (rd !== 32'h5A5A0FF0) $display("FAIL wrap_readback: got %h want 5a5a0ff0", rd); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, er; logic e, ee, st, ra; int lat;
    sel = 1'b0;
    m_req_valid = 1'b1;
    req_write   = 1'b1;
    req_addr    = 32'h20;
    req_wdata   = 32'hCAFEF00D;
    @(posedge clk); #1;
    m_req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_total++; if (m_req_ready !== 1'b1 || m_rsp_valid !== 1'b0 || m_rsp_rdata !== 32'h0 || m_rsp_err !== 1'b0)
      $display("FAIL reset_mid_outputs: got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0", m_req_ready, m_rsp_valid, m_rsp_rdata, m_rsp_err);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_model();
    do_op(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, rd, e, lat, st, ra, er, ee);
    n_total++; if (rd !== 32'h0) $display("FAIL reset_mid_load: got %h want 0", rd); else n_pass++;
    do_op(1'b0, 1'b0, 32'h08, 32'h0, 4'hF, 0, 1'b0, rd, e, lat, st, ra, er, ee);
    n_total++; if (rd !== 32'h0) $display("FAIL reset_clears_mem: got %h want 0", rd); else n_pass++;
  endtask

`ifdef DMEM_BYTE_STROBE_EN
  task automatic test_strobe();
    logic [31:0] rd, er; logic e, ee, st, ra; int lat;
    do_op(1'b0, 1'b1, 32'h10, 32'h11223344, 4'hF, 0, 1'b0, rd, e, lat, st, ra, er, ee);
    do_op(1'b0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 0, 1'b0, rd, e, lat, st, ra, er, ee);
    do_op(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, e, lat, st, ra, er, ee);
    n_total++; if (rd !== 32'h11BB33DD) $display("FAIL strobe_merge: got %h want 11bb33dd", rd); else n_pass++;
    do_op(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, 1'b0, rd, e, lat, st, ra, er, ee);
    do_op(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, e, lat, st, ra, er, ee);
    n_total++; if (rd !== 32'h11BB33DD) $display("FAIL strobe_noop: got %h want 11bb33dd", rd); else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic [31:0] rd, er, addr; logic e, ee, st, ra, s, wr; int lat, stall, want_lat;
    for (int n = 0; n < 40; n++) begin
      s    = 1'($urandom);
      wr   = 1'($urandom);
      addr = $urandom;
      if ($urandom_range(3) != 0) addr[1:0] = 2'b00;
      stall = $urandom_range(0, 3);
      want_lat = s ? 1 : WC + 1;
      do_op(s, wr, addr, $urandom, 4'($urandom), stall, 1'($urandom), rd, e, lat, st, ra, er, ee);
      n_total++; if (rd !== er) $display("FAIL rand_rdata[%0d]: got %h want %h", n, rd, er); else n_pass++;
      n_total++; if (e !== ee) $display("FAIL rand_err[%0d]: got %b want %b", n, e, ee); else n_pass++;
      n_total++; if (lat != want_lat) $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, want_lat); else n_pass++;
      n_total++; if (st !== 1'b1 || ra !== 1'b1) $display("FAIL rand_handshake[%0d]: got stable=%b ready=%b want 1 1", n, st, ra); else n_pass++;
    end
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    sel         = 1'b0;
    m_req_valid = 1'b0;
    m_rsp_ready = 1'b0;
    z_req_valid = 1'b0;
    z_rsp_ready = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_be      = 4'hF;
    clear_model();
    test_reset();
    test_store_load();
    test_misaligned();
    test_backpressure();
    test_wrap();
    test_reset_mid();
`ifdef DMEM_BYTE_STROBE_EN
    test_strobe();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the processor's load/store port: byte-addressed, big-endian, word-access data memory.
- Sits behind a valid/ready request channel and a valid/ready response channel.
- Inserts a configurable number of wait states.
- Flags misaligned accesses instead of servicing them.

Parameters:
- DEPTH, 64, memory size in bytes; must be a power of two and at least 4.
- WAIT_CYC, 2, wait-state cycles between request acceptance and response presentation; range 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store word, 0 = load word.
- req_addr  input  32  byte address; only log2(DEPTH) LSBs are used, upper bits ignored.
- req_wdata  input  32  store data; bits 31:24 go to the lowest byte address.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  load data, big-endian; zero for stores and errors.
- rsp_err  output  1  request was misaligned.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
  - All memory bytes cleared to 0.
- Reset mid-operation: any in-flight request is discarded. No write occurs unless the write's clock edge already happened.
- State machine has three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - A request is accepted when req_valid && req_ready at a rising edge.
  - Address, write flag and wdata are latched on acceptance. Later changes on the request inputs have no effect.
  - If WAIT_CYC = 0, go to RESP; otherwise load counter = WAIT_CYC and go to WAIT.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle; go to RESP on the edge where the counter goes 1 -> 0.
- RESP:
  - req_ready = 0; rsp_valid = 1 and held with stable data until rsp_ready is sampled high.
  - On that edge go to IDLE and drop rsp_valid.
- No pipelining: at most one outstanding request. The next acceptance is possible in the cycle after the response handshake.
- Latency: rsp_valid rises WAIT_CYC+1 cycles after the acceptance edge. With rsp_ready held high, a request takes WAIT_CYC+2 cycles from acceptance to the next req_ready.
- Memory access is performed on the edge that enters RESP:
  - Load: rdata = {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
  - Store: mem[a] = wdata[31:24], mem[a+1] = wdata[23:16], mem[a+2] = wdata[15:8], mem[a+3] = wdata[7:0].
  - For a store, rsp_rdata = 0.
- Address arithmetic is modulo DEPTH (a = addr[log2(DEPTH)-1:0]). An aligned word never wraps.
- Misaligned access (addr[1:0] != 0):
  - No memory update; rsp_err = 1, rsp_rdata = 0.
  - Normal latency and handshake apply.
- rsp_err and rsp_rdata are valid only while rsp_valid = 1, and are held until the response handshake.
- A req_valid asserted while busy is ignored (not accepted). The initiator must hold it until it sees req_ready.

Optional Feature:
- Macro DMEM_BYTE_STROBE_EN.
- Defined:
  - Adds input req_be[3:0]. be[3] enables the byte at a (wdata[31:24]); be[0] enables the byte at a+3 (wdata[7:0]).
  - A store writes only the enabled bytes; be = 0000 is a legal no-op store.
  - req_be is ignored for loads.
- Undefined: port absent; every store writes all four bytes.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum (IDLE/WAIT/RESP);
  - constant DMEM_WORD_BYTES = 4;
  - a function packing four bytes into a big-endian word.
- One natural sub-module, dmem_wait_counter: a loadable down-counter with a done flag.

Test Plan:
- Store then load (WAIT_CYC=2): store 0xDEADBEEF @0x08 -> rsp_valid 3 cycles after acceptance, err 0. Then load @0x08 -> rdata 0xDEADBEEF; mem[8]=0xDE, mem[11]=0xEF.
- Misaligned: load @0x05 and store 0x12345678 @0x0A -> both rsp_err=1, rdata=0; a follow-up load @0x08 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load -> rsp_valid and rdata stable, req_ready=0 throughout, and a concurrent req_valid is not accepted.
- Address wrap: store 0xA5A5A5A5 @0x7C with DEPTH=64 -> lands at 0x3C, readback @0x3C matches; WAIT_CYC=0 -> rsp_valid 1 cycle after acceptance.
- Reset mid-WAIT: drop rst_n during a store's wait -> outputs return to reset values immediately; a load at that address returns 0.
- DMEM_BYTE_STROBE_EN: over 0x11223344 @0x10, store 0xAABBCCDD with be=0101 -> load returns 0x11BB33DD.
